// File: rtl/cp0_ctrl_pkg.sv
// cp0_ctrl_pkg: shared definitions for the CP0 system-control block.
// Contents:
//   - CR_*   : CP0 register addresses as {rd[4:0], sel[2:0]}
//   - EX_*   : exception codes
//   - ST_* / CA_* : Status and Cause bit positions
//   - WB_CP0_BUS_W : width of the WB-to-CP0 exception bus
//   - is_addr_err() : identifies the exception codes that capture BadVAddr
package cp0_ctrl_pkg;

    // Register addresses, sel field always 0 for implemented registers
    localparam logic [7:0] CR_BADVADDR = {5'd8,  3'd0};
    localparam logic [7:0] CR_COUNT    = {5'd9,  3'd0};
    localparam logic [7:0] CR_COMPARE  = {5'd11, 3'd0};
    localparam logic [7:0] CR_STATUS   = {5'd12, 3'd0};
    localparam logic [7:0] CR_CAUSE    = {5'd13, 3'd0};
    localparam logic [7:0] CR_EPC      = {5'd14, 3'd0};

    // Exception codes
    localparam logic [4:0] EX_INT  = 5'd0;
    localparam logic [4:0] EX_ADEL = 5'd4;
    localparam logic [4:0] EX_ADES = 5'd5;
    localparam logic [4:0] EX_SYS  = 5'd8;
    localparam logic [4:0] EX_BP   = 5'd9;
    localparam logic [4:0] EX_RI   = 5'd10;
    localparam logic [4:0] EX_OV   = 5'd12;

    // Status bit positions
    localparam int ST_IE     = 0;
    localparam int ST_EXL    = 1;
    localparam int ST_IM_LO  = 8;
    localparam int ST_IM_HI  = 15;
    localparam int ST_BEV    = 22;

    // Cause bit positions
    localparam int CA_EXC_LO = 2;
    localparam int CA_EXC_HI = 6;
    localparam int CA_IP_LO  = 8;
    localparam int CA_IP_HI  = 15;
    localparam int CA_TI     = 30;
    localparam int CA_BD     = 31;

    // wb_ex + wb_excode + wb_badvaddr + wb_bd + wb_pc
    localparam int WB_CP0_BUS_W = 1 + 5 + 32 + 1 + 32;

    // Address-error exceptions are the only ones that update BadVAddr
    function automatic logic is_addr_err(input logic [4:0] code);
        return (code == EX_ADEL) || (code == EX_ADES);
    endfunction

endpackage

// File: rtl/cp0_timer.sv
// cp0_timer: Count/Compare timer with clock divider and timer-interrupt flag.
// Ports:
//   clk, resetn     : clock, synchronous active-low reset
//   count_we        : load Count from wdata (also restarts the divider)
//   compare_we      : load Compare from wdata (also clears TI)
//   wdata           : write data for both registers
//   count, compare  : current register values
//   ti              : timer interrupt flag (sticky until a Compare write)
module cp0_timer
    import cp0_ctrl_pkg::*;
#(
    parameter int COUNT_DIV = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        count_we,
    input  logic        compare_we,
    input  logic [31:0] wdata,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        ti
);

    // A 1-bit divider is kept even for COUNT_DIV=1; it then stays at 0
    localparam int DIV_W = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(COUNT_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

    logic [DIV_W-1:0] div_r;
    logic [31:0]      count_r;
    logic [31:0]      compare_r;
    logic             ti_r;
    logic             tick_s;

    assign tick_s = (div_r == DIV_LAST);

    // Divider, Count, Compare and TI state
    always_ff @(posedge clk) begin
        if (!resetn) begin
            div_r     <= {DIV_W{1'b0}};
            count_r   <= 32'd0;
            compare_r <= 32'd0;
            ti_r      <= 1'b0;
        end else begin
            if (count_we) begin
                count_r <= wdata;
                div_r   <= {DIV_W{1'b0}};
            end else if (tick_s) begin
                count_r <= count_r + 32'd1;
                div_r   <= {DIV_W{1'b0}};
            end else begin
                div_r   <= div_r + DIV_ONE;
            end

            // Compare write clears TI and takes precedence over a match
            if (compare_we) begin
                compare_r <= wdata;
                ti_r      <= 1'b0;
            end else if (count_r == compare_r) begin
                ti_r      <= 1'b1;
            end
        end
    end

    assign count   = count_r;
    assign compare = compare_r;
    assign ti      = ti_r;

endmodule

// File: rtl/cp0_ctrl.sv
// cp0_ctrl: CP0 system-control block (BadVAddr, Count, Compare, Status,
// Cause, EPC) sitting beside the WB stage.
// Ports:
//   clk, resetn        : clock, synchronous active-low reset
//   ext_int_in         : level-sensitive hardware interrupt lines
//   wb_ex, wb_excode, wb_badvaddr, wb_bd, wb_pc : exception commit from WB
//   eret_flush         : ERET commits this cycle
//   mtc0_we, c0_addr, c0_wdata : MTC0 write port ({rd, sel} address)
//   c0_rdata           : MFC0 read data (combinational, no forwarding)
//   epc_out            : ERET target
//   ex_entry           : exception vector
//   int_req            : registered interrupt request
module cp0_ctrl
    import cp0_ctrl_pkg::*;
#(
    parameter int          EXT_INT_W = 6,
    parameter int          COUNT_DIV = 2,
    parameter logic [31:0] EBASE     = 32'h8000_0000,
    parameter bit          BEV_RST   = 1'b1
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [EXT_INT_W-1:0] ext_int_in,
    input  logic                 wb_ex,
    input  logic [4:0]           wb_excode,
    input  logic [31:0]          wb_badvaddr,
    input  logic                 wb_bd,
    input  logic [31:0]          wb_pc,
    input  logic                 eret_flush,
    input  logic                 mtc0_we,
    input  logic [7:0]           c0_addr,
    input  logic [31:0]          c0_wdata,
    output logic [31:0]          c0_rdata,
    output logic [31:0]          epc_out,
    output logic [31:0]          ex_entry,
    output logic                 int_req
);

    // Status fields
    logic        bev_r;
    logic [7:0]  im_r;
    logic        exl_r;
    logic        ie_r;
    // Cause fields
    logic        bd_r;
    logic [7:2]  ip_hw_r;
    logic [1:0]  ip_sw_r;
    logic [4:0]  excode_r;
    // Other registers
    logic [31:0] badvaddr_r;
    logic [31:0] epc_r;
    logic        int_req_r;

    logic        mtc0_ok_s;
    logic        count_we_s;
    logic        compare_we_s;
    logic [31:0] count_s;
    logic [31:0] compare_s;
    logic        ti_s;
    logic [5:0]  ext_pad_s;
    logic [7:2]  ip_hw_next_s;
    logic [7:0]  ip_s;
    logic        int_req_next_s;
    logic [31:0] status_s;
    logic [31:0] cause_s;

    // An MTC0 only lands when neither an exception nor an ERET commits
    assign mtc0_ok_s    = mtc0_we & ~wb_ex & ~eret_flush;
    assign count_we_s   = mtc0_ok_s & (c0_addr == CR_COUNT);
    assign compare_we_s = mtc0_ok_s & (c0_addr == CR_COMPARE);

    cp0_timer #(
        .COUNT_DIV (COUNT_DIV)
    ) u_timer (
        .clk        (clk),
        .resetn     (resetn),
        .count_we   (count_we_s),
        .compare_we (compare_we_s),
        .wdata      (c0_wdata),
        .count      (count_s),
        .compare    (compare_s),
        .ti         (ti_s)
    );

    // Zero-extend the external lines to the full six IP[7:2] slots
    always_comb begin
        ext_pad_s = 6'd0;
        for (int i = 0; i < EXT_INT_W; i++) begin
            ext_pad_s[i] = ext_int_in[i];
        end
    end

    assign ip_hw_next_s   = {ext_pad_s[5] | ti_s, ext_pad_s[4:0]};
    assign ip_s           = {ip_hw_r, ip_sw_r};
    assign int_req_next_s = ie_r & ~exl_r & (|(ip_s & im_r));

    // Architectural register updates: wb_ex > eret_flush > mtc0_we
    always_ff @(posedge clk) begin
        if (!resetn) begin
            bev_r      <= BEV_RST;
            im_r       <= 8'd0;
            exl_r      <= 1'b0;
            ie_r       <= 1'b0;
            bd_r       <= 1'b0;
            ip_hw_r    <= 6'd0;
            ip_sw_r    <= 2'd0;
            excode_r   <= 5'd0;
            badvaddr_r <= 32'd0;
            epc_r      <= 32'd0;
            int_req_r  <= 1'b0;
        end else begin
            ip_hw_r   <= ip_hw_next_s;
            int_req_r <= int_req_next_s;

            if (wb_ex) begin
                exl_r    <= 1'b1;
                excode_r <= wb_excode;
                // A nested exception keeps the original return point
                if (!exl_r) begin
                    epc_r <= wb_bd ? (wb_pc - 32'd4) : wb_pc;
                    bd_r  <= wb_bd;
                end
                if (is_addr_err(wb_excode)) begin
                    badvaddr_r <= wb_badvaddr;
                end
            end else if (eret_flush) begin
                exl_r <= 1'b0;
            end else if (mtc0_we) begin
                case (c0_addr)
                    CR_STATUS: begin
                        bev_r <= c0_wdata[ST_BEV];
                        im_r  <= c0_wdata[ST_IM_HI:ST_IM_LO];
                        exl_r <= c0_wdata[ST_EXL];
                        ie_r  <= c0_wdata[ST_IE];
                    end
                    CR_CAUSE: begin
                        ip_sw_r <= c0_wdata[CA_IP_LO+1:CA_IP_LO];
                    end
                    CR_EPC: begin
                        epc_r <= c0_wdata;
                    end
                    default: begin
                        // Count/Compare handled in the timer; others read-only
                    end
                endcase
            end
        end
    end

    assign status_s = {9'd0, bev_r, 6'd0, im_r, 6'd0, exl_r, ie_r};
    assign cause_s  = {bd_r, ti_s, 14'd0, ip_s, 1'b0, excode_r, 2'd0};

    // MFC0 read mux, current state only
    always_comb begin
        c0_rdata = 32'd0;
        case (c0_addr)
            CR_BADVADDR: c0_rdata = badvaddr_r;
            CR_COUNT:    c0_rdata = count_s;
            CR_COMPARE:  c0_rdata = compare_s;
            CR_STATUS:   c0_rdata = status_s;
            CR_CAUSE:    c0_rdata = cause_s;
            CR_EPC:      c0_rdata = epc_r;
            default:     c0_rdata = 32'd0;
        endcase
    end

    assign epc_out  = epc_r;
    assign ex_entry = bev_r ? 32'hBFC0_0380 : (EBASE + 32'h0000_0180);
    assign int_req  = int_req_r;

endmodule
